// File: rtl/instr_stage_sequencer.sv
// Instruction stage sequencer for the multi-cycle core.
// Holds a small circular fetch queue, issues one instruction at a time and
// steps it through a per-instruction number of stages. Stall holds the
// current stage, flush drops everything, and retirements are counted.
//
// state | meaning
// IDLE  | no instruction executing, waiting for a queued word
// EXEC  | issue_instr is executing, stage counts up to eff_stages-1

module instr_stage_sequencer #(
    parameter int NUM_STAGES  = 5,
    parameter int STAGE_W     = 3,
    parameter int INSTR_W     = 32,
    parameter int FETCH_DEPTH = 2,
    parameter int PTR_W       = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_valid,
    input  logic [INSTR_W-1:0] fetch_data,
    output logic               fetch_ready,
    input  logic [STAGE_W-1:0] instr_num_stages,
    input  logic               stall,
    input  logic               flush,
    output logic [INSTR_W-1:0] issue_instr,
    output logic               issue_valid,
    output logic [STAGE_W-1:0] stage,
    output logic               stage_last,
    output logic               retire,
    output logic [PTR_W:0]     queue_count,
    output logic [31:0]        retired_count
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    // One extra bit so NUM_STAGES == 2**STAGE_W still fits.
    localparam logic [STAGE_W:0] MAX_STAGES = (STAGE_W+1)'(NUM_STAGES);
    localparam logic [PTR_W:0]   DEPTH      = (PTR_W+1)'(FETCH_DEPTH);

    state_t             state;
    logic [INSTR_W-1:0] queue_mem [FETCH_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [INSTR_W-1:0] head;
    logic [STAGE_W:0]   eff_stages;
    logic [STAGE_W-1:0] last_idx;
    logic               push;
    logic               pop;

    // Clamp the decoder's stage count into 1..NUM_STAGES.
    always_comb begin
        eff_stages = {1'b0, instr_num_stages};
        if (instr_num_stages == '0) begin
            eff_stages = (STAGE_W+1)'(1);
        end else if ({1'b0, instr_num_stages} > MAX_STAGES) begin
            eff_stages = MAX_STAGES;
        end
    end

    assign last_idx    = STAGE_W'(eff_stages - 1'b1);
    assign head        = queue_mem[rd_ptr];

    // Ready is taken from the registered count only, so a full queue refuses
    // a push even in a cycle where the head is being popped.
    assign fetch_ready = (queue_count < DEPTH);
    assign stage_last  = issue_valid && (stage == last_idx);
    assign retire      = stage_last && !stall && !flush;

    assign push = fetch_valid && fetch_ready && !flush;
    assign pop  = !flush && !stall && (queue_count != '0) &&
                  ((state == IDLE) || stage_last);

    // Queue storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            queue_mem[wr_ptr] <= fetch_data;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            queue_count <= '0;
        end else if (flush) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            queue_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   queue_count <= queue_count + 1'b1;
                2'b01:   queue_count <= queue_count - 1'b1;
                default: queue_count <= queue_count;
            endcase
        end
    end

    // Issue / stage FSM with registered outputs and the retire counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            issue_instr   <= '0;
            issue_valid   <= 1'b0;
            stage         <= '0;
            retired_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        issue_instr <= head;
                        issue_valid <= 1'b1;
                        stage       <= '0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (flush) begin
                        issue_valid <= 1'b0;
                        stage       <= '0;
                        state       <= IDLE;
                    end else if (stall) begin
                        state <= EXEC;
                    end else if (!stage_last) begin
                        stage <= stage + 1'b1;
                    end else begin
                        retired_count <= retired_count + 32'd1;
                        if (pop) begin
                            issue_instr <= head;
                            stage       <= '0;
                        end else begin
                            issue_valid <= 1'b0;
                            stage       <= '0;
                            state       <= IDLE;
                        end
                    end
                end
                default: begin
                    issue_valid <= 1'b0;
                    stage       <= '0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_stage_sequencer.sv
// Self-checking bench for instr_stage_sequencer. The bench plays the decoder:
// the low three bits of each instruction word carry its stage count.

`timescale 1ns/1ps

module tb_instr_stage_sequencer;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic [2:0]  instr_num_stages;
    logic        stall;
    logic        flush;
    logic [31:0] issue_instr;
    logic        issue_valid;
    logic [2:0]  stage;
    logic        stage_last;
    logic        retire;
    logic [1:0]  queue_count;
    logic [31:0] retired_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_retired = 0;
    logic [31:0] exp_q [$];

    instr_stage_sequencer #(
        .NUM_STAGES (5),
        .STAGE_W    (3),
        .INSTR_W    (32),
        .FETCH_DEPTH(2),
        .PTR_W      (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_valid     (fetch_valid),
        .fetch_data      (fetch_data),
        .fetch_ready     (fetch_ready),
        .instr_num_stages(instr_num_stages),
        .stall           (stall),
        .flush           (flush),
        .issue_instr     (issue_instr),
        .issue_valid     (issue_valid),
        .stage           (stage),
        .stage_last      (stage_last),
        .retire          (retire),
        .queue_count     (queue_count),
        .retired_count   (retired_count)
    );

    assign instr_num_stages = issue_instr[2:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int eff_of(input logic [31:0] w);
        int n;
        n = int'(w[2:0]);
        if (n == 0) return 1;
        if (n > 5) return 5;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every retirement must be the oldest expected word, in its last stage.
    always @(negedge clk) begin
        if (rst && retire) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_retire: got instr %h, want no retire", issue_instr);
            end else begin
                logic [31:0] w;
                w = exp_q.pop_front();
                if (issue_instr !== w || int'(stage) != eff_of(w) - 1)
                    $display("FAIL sb_retire: got instr %h stage %0d, want instr %h stage %0d",
                             issue_instr, stage, w, eff_of(w) - 1);
                else n_pass++;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0; fetch_valid = 1'b0; fetch_data = '0; stall = 1'b0; flush = 1'b0;
        tick(); tick();
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL rst_issue_valid: got %b want 0", issue_valid); else n_pass++;
        n_checks++; if (stage !== 3'd0) $display("FAIL rst_stage: got %0d want 0", stage); else n_pass++;
        n_checks++; if (queue_count !== 2'd0) $display("FAIL rst_count: got %0d want 0", queue_count); else n_pass++;
        n_checks++; if (fetch_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", fetch_ready); else n_pass++;
        n_checks++; if (retired_count !== 32'd0) $display("FAIL rst_retired: got %0d want 0", retired_count); else n_pass++;
        n_checks++; if (issue_instr !== 32'd0) $display("FAIL rst_instr: got %h want 0", issue_instr); else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [31:0] a;
        a = 32'hA000_0003;
        fetch_valid = 1'b1; fetch_data = a; exp_q.push_back(a);
        tick();
        fetch_valid = 1'b0; #1;
        n_checks++; if (issue_valid !== 1'b0 || queue_count !== 2'd1)
            $display("FAIL single_no_bypass: got valid %b count %0d want 0 1", issue_valid, queue_count); else n_pass++;
        for (int s = 0; s < 3; s++) begin
            tick();
            n_checks++; if (issue_valid !== 1'b1 || stage !== 3'(s) || issue_instr !== a)
                $display("FAIL single_stage: got valid %b stage %0d instr %h want 1 %0d %h", issue_valid, stage, issue_instr, s, a); else n_pass++;
            n_checks++; if (retire !== (s == 2))
                $display("FAIL single_retire: got %b want %b at stage %0d", retire, (s == 2), s); else n_pass++;
        end
        tick();
        exp_retired += 1;
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL single_idle: got %b want 0", issue_valid); else n_pass++;
        n_checks++; if (retired_count !== 32'(exp_retired))
            $display("FAIL single_retired: got %0d want %0d", retired_count, exp_retired); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        a = 32'hB000_0002; b = 32'hB100_0004;
        fetch_valid = 1'b1; fetch_data = a; exp_q.push_back(a);
        tick();
        fetch_data = b; exp_q.push_back(b);
        tick();
        fetch_valid = 1'b0; #1;
        n_checks++; if (issue_instr !== a || stage !== 3'd0 || queue_count !== 2'd1)
            $display("FAIL b2b_a_issue: got instr %h stage %0d count %0d want %h 0 1", issue_instr, stage, queue_count, a); else n_pass++;
        tick();
        n_checks++; if (retire !== 1'b1) $display("FAIL b2b_a_retire: got %b want 1", retire); else n_pass++;
        tick();
        n_checks++; if (issue_valid !== 1'b1 || issue_instr !== b || stage !== 3'd0)
            $display("FAIL b2b_no_bubble: got valid %b instr %h stage %0d want 1 %h 0", issue_valid, issue_instr, stage, b); else n_pass++;
        for (int s = 1; s < 4; s++) begin
            tick();
            n_checks++; if (stage !== 3'(s) || retire !== (s == 3))
                $display("FAIL b2b_b_stage: got stage %0d retire %b want %0d %b", stage, retire, s, (s == 3)); else n_pass++;
        end
        tick();
        exp_retired += 2;
        n_checks++; if (issue_valid !== 1'b0 || retired_count !== 32'(exp_retired))
            $display("FAIL b2b_done: got valid %b retired %0d want 0 %0d", issue_valid, retired_count, exp_retired); else n_pass++;
    endtask

    task automatic test_full();
        logic [31:0] d, e, f, c;
        bit done;
        d = 32'hD000_0005; e = 32'hE000_0002; f = 32'hF000_0001; c = 32'hCC00_0003;
        fetch_valid = 1'b1; fetch_data = d; exp_q.push_back(d);
        tick();
        fetch_data = e; exp_q.push_back(e);
        tick();
        fetch_data = f; exp_q.push_back(f);
        tick();
        fetch_data = c; #1;
        n_checks++; if (fetch_ready !== 1'b0 || queue_count !== 2'd2)
            $display("FAIL full_ready: got ready %b count %0d want 0 2", fetch_ready, queue_count); else n_pass++;
        tick();
        n_checks++; if (queue_count !== 2'd2 || stage !== 3'd2)
            $display("FAIL full_drop: got count %0d stage %0d want 2 2", queue_count, stage); else n_pass++;
        tick(); tick();
        n_checks++; if (retire !== 1'b1 || fetch_ready !== 1'b0)
            $display("FAIL full_pop_cycle: got retire %b ready %b want 1 0", retire, fetch_ready); else n_pass++;
        tick();
        fetch_valid = 1'b0;
        n_checks++; if (queue_count !== 2'd1 || issue_instr !== e || stage !== 3'd0)
            $display("FAIL full_refused_at_pop: got count %0d instr %h stage %0d want 1 %h 0", queue_count, issue_instr, stage, e); else n_pass++;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (!issue_valid && queue_count == 2'd0) done = 1'b1;
        end
        exp_retired += 3;
        n_checks++; if (!done) $display("FAIL full_drain: got busy after 40 cycles want idle"); else n_pass++;
        n_checks++; if (retired_count !== 32'(exp_retired))
            $display("FAIL full_retired: got %0d want %0d", retired_count, exp_retired); else n_pass++;
    endtask

    task automatic test_stall_flush();
        fetch_valid = 1'b1; fetch_data = 32'h6000_0004;
        tick();
        fetch_data = 32'h6100_0003;
        tick();
        fetch_valid = 1'b0;
        tick();
        stall = 1'b1; fetch_valid = 1'b1; fetch_data = 32'h6200_0002; #1;
        n_checks++; if (stage !== 3'd1 || retire !== 1'b0)
            $display("FAIL stall_entry: got stage %0d retire %b want 1 0", stage, retire); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            fetch_valid = 1'b0; #1;
            n_checks++; if (stage !== 3'd1 || retire !== 1'b0 || issue_valid !== 1'b1)
                $display("FAIL stall_hold: got stage %0d retire %b valid %b want 1 0 1", stage, retire, issue_valid); else n_pass++;
        end
        n_checks++; if (queue_count !== 2'd2)
            $display("FAIL stall_push: got count %0d want 2", queue_count); else n_pass++;
        flush = 1'b1; fetch_valid = 1'b1; fetch_data = 32'h6300_0001; #1;
        n_checks++; if (retire !== 1'b0) $display("FAIL flush_retire: got %b want 0", retire); else n_pass++;
        tick();
        flush = 1'b0; stall = 1'b0; fetch_valid = 1'b0;
        n_checks++; if (issue_valid !== 1'b0 || stage !== 3'd0 || queue_count !== 2'd0)
            $display("FAIL flush_state: got valid %b stage %0d count %0d want 0 0 0", issue_valid, stage, queue_count); else n_pass++;
        n_checks++; if (retired_count !== 32'(exp_retired))
            $display("FAIL flush_retired: got %0d want %0d", retired_count, exp_retired); else n_pass++;
        tick();
        n_checks++; if (issue_valid !== 1'b0)
            $display("FAIL flush_push_dropped: got valid %b want 0", issue_valid); else n_pass++;
    endtask

    task automatic test_clamp();
        logic [31:0] k, l;
        k = 32'h8000_0000; l = 32'h8100_0007;
        fetch_valid = 1'b1; fetch_data = k; exp_q.push_back(k);
        tick();
        fetch_valid = 1'b0;
        tick();
        n_checks++; if (stage !== 3'd0 || retire !== 1'b1 || stage_last !== 1'b1)
            $display("FAIL clamp_zero: got stage %0d retire %b last %b want 0 1 1", stage, retire, stage_last); else n_pass++;
        tick();
        n_checks++; if (issue_valid !== 1'b0) $display("FAIL clamp_zero_idle: got %b want 0", issue_valid); else n_pass++;
        fetch_valid = 1'b1; fetch_data = l; exp_q.push_back(l);
        tick();
        fetch_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            n_checks++; if (stage !== 3'(s) || retire !== (s == 4))
                $display("FAIL clamp_max: got stage %0d retire %b want %0d %b", stage, retire, s, (s == 4)); else n_pass++;
        end
        tick();
        exp_retired += 2;
        n_checks++; if (issue_valid !== 1'b0 || retired_count !== 32'(exp_retired))
            $display("FAIL clamp_done: got valid %b retired %0d want 0 %0d", issue_valid, retired_count, exp_retired); else n_pass++;
    endtask

    task automatic test_reset_midop();
        fetch_valid = 1'b1; fetch_data = 32'h7000_0005;
        tick();
        fetch_data = 32'h7100_0004;
        tick();
        fetch_data = 32'h7200_0003;
        tick();
        fetch_valid = 1'b0;
        tick();
        n_checks++; if (stage !== 3'd2 || queue_count !== 2'd2 || issue_valid !== 1'b1)
            $display("FAIL midop_setup: got stage %0d count %0d valid %b want 2 2 1", stage, queue_count, issue_valid); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (issue_valid !== 1'b0 || stage !== 3'd0 || issue_instr !== 32'd0 || retire !== 1'b0)
            $display("FAIL midop_async: got valid %b stage %0d instr %h retire %b want 0 0 0 0", issue_valid, stage, issue_instr, retire); else n_pass++;
        n_checks++; if (queue_count !== 2'd0 || fetch_ready !== 1'b1 || retired_count !== 32'd0)
            $display("FAIL midop_queue: got count %0d ready %b retired %0d want 0 1 0", queue_count, fetch_ready, retired_count); else n_pass++;
        exp_retired = 0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_stall_flush();
        test_clamp();
        test_reset_midop();
        n_checks++; if (exp_q.size() != 0)
            $display("FAIL sb_leftover: got %0d unretired words want 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion want finish before 200000ns");
        $fatal(1, "timeout");
    end

endmodule
